// File: rtl/pipe_pkg.sv
// Shared types and constants for the elastic inter-stage pipeline registers.
package pipe_pkg;

    localparam int DEF_CTRL_W = 8;
    localparam int DEF_DATA_W = 128;
    localparam int DEF_CNT_W  = 16;

    localparam logic [DEF_CTRL_W-1:0] NOP_CTRL = '0;

    typedef enum logic [1:0] {
        IF_ID,
        ID_EX,
        EX_MEM,
        MEM_WB
    } stage_id_t;

    typedef struct packed {
        logic                  v;
        logic [DEF_CTRL_W-1:0] ctrl;
        logic [DEF_DATA_W-1:0] data;
    } stage_entry_t;

    function automatic logic [1:0] occ_count(input logic main_v, input logic skid_v);
        return {1'b0, main_v} + {1'b0, skid_v};
    endfunction

endpackage

// File: rtl/pipe_entry_reg.sv
// One pipeline entry: valid bit plus control/data fields, with clear, load and invalidate.
module pipe_entry_reg
    import pipe_pkg::*;
#(
    parameter int                CTRL_W   = DEF_CTRL_W,
    parameter int                DATA_W   = DEF_DATA_W,
    parameter logic [CTRL_W-1:0] CTRL_RST = '0
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              clear,
    input  logic              load,
    input  logic              invalidate,
    input  logic [CTRL_W-1:0] load_ctrl,
    input  logic [DATA_W-1:0] load_data,
    output logic              v,
    output logic [CTRL_W-1:0] ctrl,
    output logic [DATA_W-1:0] data
);

    // Invalidate only drops the valid bit, so the data field is held for the downstream stage.
    always_ff @(posedge CLK) begin
        if (RST || clear) begin
            v    <= 1'b0;
            ctrl <= CTRL_RST;
            data <= '0;
        end else if (load) begin
            v    <= 1'b1;
            ctrl <= load_ctrl;
            data <= load_data;
        end else if (invalidate) begin
            v    <= 1'b0;
        end
    end

endmodule

// File: rtl/pipe_stage_elastic.sv
// Elastic inter-stage pipeline register with valid/ready handshake, hold/flush control,
// optional skid entry and a saturating stall counter.
module pipe_stage_elastic
    import pipe_pkg::*;
#(
    parameter int                CTRL_W   = DEF_CTRL_W,
    parameter int                DATA_W   = DEF_DATA_W,
    parameter logic [CTRL_W-1:0] CTRL_RST = '0,
    parameter int                SKID     = 1,
    parameter int                CNT_W    = DEF_CNT_W
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_drop,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    input  logic              hold,
    input  logic              flush,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  stall_cnt
);

    logic              main_v;
    logic [CTRL_W-1:0] main_ctrl;
    logic [DATA_W-1:0] main_data;
    logic              skid_v;
    logic [CTRL_W-1:0] skid_ctrl;
    logic [DATA_W-1:0] skid_data;

    logic accept, rel, store;
    logic main_load, main_inv, main_from_skid;
    logic skid_load, skid_inv;
    logic [CTRL_W-1:0] main_next_ctrl;
    logic [DATA_W-1:0] main_next_data;

    assign out_valid = main_v & ~hold;
    assign in_ready  = ~hold & ~RST & ((SKID != 0) ? ~skid_v : (~main_v | out_ready));
    assign accept    = in_valid & in_ready;
    assign rel       = out_valid & out_ready;
    assign store     = accept & ~in_drop;

    // Invalid entries present the nop control so no stale write enable leaks downstream.
    assign out_ctrl  = out_valid ? main_ctrl : CTRL_RST;
    assign out_data  = main_data;
    assign occupancy = occ_count(main_v, skid_v);

    always_comb begin
        main_load      = 1'b0;
        main_inv       = 1'b0;
        main_from_skid = 1'b0;
        skid_load      = 1'b0;
        skid_inv       = 1'b0;
        if (SKID != 0) begin
            if (rel && skid_v) begin
                main_load      = 1'b1;
                main_from_skid = 1'b1;
                skid_load      = store;
                skid_inv       = ~store;
            end else if (rel) begin
                main_load = store;
                main_inv  = ~store;
            end else if (main_v) begin
                skid_load = store;
            end else begin
                main_load = store;
            end
        end else begin
            main_load = store & (~main_v | rel);
            main_inv  = rel & ~store;
        end
    end

    assign main_next_ctrl = main_from_skid ? skid_ctrl : in_ctrl;
    assign main_next_data = main_from_skid ? skid_data : in_data;

    pipe_entry_reg #(
        .CTRL_W   (CTRL_W),
        .DATA_W   (DATA_W),
        .CTRL_RST (CTRL_RST)
    ) u_main (
        .CLK        (CLK),
        .RST        (RST),
        .clear      (flush),
        .load       (main_load),
        .invalidate (main_inv),
        .load_ctrl  (main_next_ctrl),
        .load_data  (main_next_data),
        .v          (main_v),
        .ctrl       (main_ctrl),
        .data       (main_data)
    );

    generate
        if (SKID != 0) begin : g_skid
            pipe_entry_reg #(
                .CTRL_W   (CTRL_W),
                .DATA_W   (DATA_W),
                .CTRL_RST (CTRL_RST)
            ) u_skid (
                .CLK        (CLK),
                .RST        (RST),
                .clear      (flush),
                .load       (skid_load),
                .invalidate (skid_inv),
                .load_ctrl  (in_ctrl),
                .load_data  (in_data),
                .v          (skid_v),
                .ctrl       (skid_ctrl),
                .data       (skid_data)
            );
        end else begin : g_noskid
            assign skid_v    = 1'b0;
            assign skid_ctrl = CTRL_RST;
            assign skid_data = '0;
        end
    endgenerate

    // Stall history survives flush; only reset clears it.
    always_ff @(posedge CLK) begin
        if (RST) begin
            stall_cnt <= '0;
        end else if (main_v && (hold || !out_ready) && !(&stall_cnt)) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Bench for pipe_stage_elastic: skid and no-skid instances share stimulus and are
// compared each cycle against a FIFO-style reference model.
module tb_pipe_stage_elastic;

    localparam int         CW   = 8;
    localparam int         DW   = 16;
    localparam int         NW   = 4;
    localparam logic [7:0] CRST = 8'hE0;

    logic          CLK = 1'b0;
    logic          RST, in_valid, in_drop, out_ready, hold, flush;
    logic [CW-1:0] in_ctrl;
    logic [DW-1:0] in_data;

    logic          rdyA, ovA, rdyB, ovB;
    logic [CW-1:0] ctrlA, ctrlB;
    logic [DW-1:0] dataA, dataB;
    logic [1:0]    occA, occB;
    logic [NW-1:0] cntA, cntB;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: per instance an ordered list of stored beats {ctrl,data}.
    logic [23:0]   mq [2][2];
    int            mcnt [2];
    logic [15:0]   mHead [2];
    logic [NW-1:0] mStall [2];

    always #5 CLK = ~CLK;

    pipe_stage_elastic #(.CTRL_W(CW), .DATA_W(DW), .CTRL_RST(CRST), .SKID(1), .CNT_W(NW)) u_skid (
        .CLK(CLK), .RST(RST), .in_valid(in_valid), .in_ready(rdyA), .in_drop(in_drop),
        .in_ctrl(in_ctrl), .in_data(in_data), .out_valid(ovA), .out_ready(out_ready),
        .out_ctrl(ctrlA), .out_data(dataA), .hold(hold), .flush(flush),
        .occupancy(occA), .stall_cnt(cntA)
    );

    pipe_stage_elastic #(.CTRL_W(CW), .DATA_W(DW), .CTRL_RST(CRST), .SKID(0), .CNT_W(NW)) u_noskid (
        .CLK(CLK), .RST(RST), .in_valid(in_valid), .in_ready(rdyB), .in_drop(in_drop),
        .in_ctrl(in_ctrl), .in_data(in_data), .out_valid(ovB), .out_ready(out_ready),
        .out_ctrl(ctrlB), .out_data(dataB), .hold(hold), .flush(flush),
        .occupancy(occB), .stall_cnt(cntB)
    );

    function automatic logic expReady(input int d);
        if (hold || RST) return 1'b0;
        if (d == 0) return mcnt[d] < 2;
        return (mcnt[d] == 0) || out_ready;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic checkAll();
        for (int d = 0; d < 2; d++) begin
            logic        ovExp;
            logic [7:0]  ctrlExp;
            ovExp   = (mcnt[d] > 0) && !hold;
            ctrlExp = ovExp ? mq[d][0][23:16] : CRST;
            checkOutput($sformatf("u%0d_in_ready", d),  d == 0 ? rdyA  : rdyB,  expReady(d));
            checkOutput($sformatf("u%0d_out_valid", d), d == 0 ? ovA   : ovB,   ovExp);
            checkOutput($sformatf("u%0d_out_ctrl", d),  d == 0 ? ctrlA : ctrlB, ctrlExp);
            checkOutput($sformatf("u%0d_out_data", d),  d == 0 ? dataA : dataB, mHead[d]);
            checkOutput($sformatf("u%0d_occupancy", d), d == 0 ? occA  : occB,  mcnt[d]);
            checkOutput($sformatf("u%0d_stall_cnt", d), d == 0 ? cntA  : cntB,  mStall[d]);
        end
    endtask

    task automatic modelStep();
        for (int d = 0; d < 2; d++) begin
            if (RST) begin
                mcnt[d]   = 0;
                mHead[d]  = '0;
                mStall[d] = '0;
            end else begin
                logic acc, rel;
                acc = in_valid && expReady(d);
                rel = (mcnt[d] > 0) && !hold && out_ready;
                if ((mcnt[d] > 0) && (hold || !out_ready) && mStall[d] != 4'hF)
                    mStall[d] = mStall[d] + 4'd1;
                if (flush) begin
                    mcnt[d]  = 0;
                    mHead[d] = '0;
                end else begin
                    if (rel) begin
                        mq[d][0] = mq[d][1];
                        mcnt[d]--;
                    end
                    if (acc && !in_drop) begin
                        mq[d][mcnt[d]] = {in_ctrl, in_data};
                        mcnt[d]++;
                    end
                    if (mcnt[d] > 0) mHead[d] = mq[d][0][15:0];
                end
            end
        end
    endtask

    task automatic applyStimulus(input logic iv, input logic drop, input logic [7:0] tag,
                                 input logic ordy, input logic hld, input logic fl,
                                 input logic rst);
        in_valid  = iv;
        in_drop   = drop;
        in_ctrl   = tag;
        in_data   = {tag, tag ^ 8'h5A};
        out_ready = ordy;
        hold      = hld;
        flush     = fl;
        RST       = rst;
        #2;
        checkAll();
        @(posedge CLK);
        modelStep();
        #1;
    endtask

    initial begin
        RST = 1'b1; in_valid = 1'b0; in_drop = 1'b0; in_ctrl = '0; in_data = '0;
        out_ready = 1'b0; hold = 1'b0; flush = 1'b0;
        @(posedge CLK);
        #1;
        for (int d = 0; d < 2; d++) begin
            mcnt[d] = 0; mHead[d] = '0; mStall[d] = '0;
            mq[d][0] = '0; mq[d][1] = '0;
        end
        checkAll();

        $display("[TB] streaming A1..A4");
        for (int i = 0; i < 4; i++) applyStimulus(1, 0, 8'hA1 + 8'(i), 1, 0, 0, 0);
        applyStimulus(0, 0, 8'h00, 1, 0, 0, 0);
        applyStimulus(0, 0, 8'h00, 1, 0, 0, 0);

        $display("[TB] skid fill and drain");
        applyStimulus(1, 0, 8'hA1, 0, 0, 0, 0);
        applyStimulus(1, 0, 8'hA2, 0, 0, 0, 0);
        checkOutput("t2_occ",      occA,  2);
        checkOutput("t2_in_ready", rdyA,  0);
        checkOutput("t2_main",     dataA, 16'hA1FB);
        applyStimulus(0, 0, 8'h00, 1, 0, 0, 0);
        applyStimulus(0, 0, 8'h00, 1, 0, 0, 0);
        applyStimulus(0, 0, 8'h00, 1, 0, 0, 0);

        $display("[TB] flush with incoming beat");
        applyStimulus(1, 0, 8'hB2, 0, 0, 0, 0);
        applyStimulus(1, 0, 8'hB3, 0, 0, 0, 0);
        applyStimulus(1, 0, 8'hB1, 0, 0, 1, 0);
        checkOutput("t3_out_valid", ovA,   0);
        checkOutput("t3_out_ctrl",  ctrlA, CRST);
        checkOutput("t3_occ",       occA,  0);
        applyStimulus(0, 0, 8'h00, 1, 0, 0, 0);
        applyStimulus(0, 0, 8'h00, 1, 0, 0, 0);

        $display("[TB] hold for three cycles");
        applyStimulus(1, 0, 8'hC1, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) applyStimulus(0, 0, 8'h00, 1, 1, 0, 0);
        checkOutput("t4_held_data", dataA, 16'hC19B);
        applyStimulus(0, 0, 8'h00, 1, 0, 0, 0);
        applyStimulus(0, 0, 8'h00, 1, 0, 0, 0);

        $display("[TB] dropped beat becomes a bubble");
        applyStimulus(1, 0, 8'hD0, 1, 0, 0, 0);
        applyStimulus(1, 1, 8'hD1, 1, 0, 0, 0);
        applyStimulus(1, 0, 8'hD2, 1, 0, 0, 0);
        applyStimulus(0, 0, 8'h00, 1, 0, 0, 0);
        applyStimulus(0, 0, 8'h00, 1, 0, 0, 0);

        $display("[TB] stall saturation and reset pulse");
        applyStimulus(0, 0, 8'h00, 1, 0, 0, 1);
        applyStimulus(1, 0, 8'hE1, 0, 0, 0, 0);
        for (int i = 0; i < 20; i++) applyStimulus(0, 0, 8'h00, 0, 0, 0, 0);
        checkOutput("t6_sat_skid",   cntA, 4'hF);
        checkOutput("t6_sat_noskid", cntB, 4'hF);
        applyStimulus(1, 0, 8'hE2, 1, 0, 0, 1);
        checkOutput("t6_rst_occ",   occA,  0);
        checkOutput("t6_rst_cnt",   cntA,  0);
        checkOutput("t6_rst_valid", ovA,   0);
        checkOutput("t6_rst_data",  dataA, 0);

        $display("[TB] randomized traffic");
        for (int i = 0; i < 600; i++) begin
            logic iv, dr, ordy, hld, fl, rst;
            iv   = ($urandom_range(0, 3) != 0);
            dr   = ($urandom_range(0, 5) == 0);
            ordy = (i % 100 < 30) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 1) == 1);
            hld  = ($urandom_range(0, 7) == 0);
            fl   = ($urandom_range(0, 15) == 0);
            rst  = ($urandom_range(0, 63) == 0);
            applyStimulus(iv, dr, 8'($urandom_range(0, 255)), ordy, hld, fl, rst);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
